// File: rtl/gvt_reducer_pkg.sv
// Shared types and helpers for the GVT reduction stage.
// Timestamp widths are parameters, so VT values travel as flat {ts, tb} vectors.
package gvt_reducer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REDUCE
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gvt_reducer_if.sv
// LVT request/response and GVT broadcast bundle.
// The master side is the reducer; the slave side is the tiles plus the GVT consumer.
interface gvt_reducer_if #(
  parameter int N_TILES  = 1,
  parameter int TS_WIDTH = 32,
  parameter int TB_WIDTH = 32
);
  localparam int VT_WIDTH = TS_WIDTH + TB_WIDTH;

  logic                              enable;
  logic                              lvt_req;
  logic [N_TILES-1:0]                lvt_valid;
  logic [N_TILES-1:0][VT_WIDTH-1:0]  lvt;
  logic [VT_WIDTH-1:0]               gvt;
  logic                              gvt_valid;
  logic                              gvt_regress;
  logic [15:0]                       missed_periods;

  modport master (
    input  enable, lvt_valid, lvt,
    output lvt_req, gvt, gvt_valid, gvt_regress, missed_periods
  );

  modport slave (
    output enable, lvt_valid, lvt,
    input  lvt_req, gvt, gvt_valid, gvt_regress, missed_periods
  );
endinterface

// File: rtl/min_vt_tree.sv
// Registered binary minimum tree, one pipeline stage per level (needs N >= 2).
// Missing operands are padded with all-ones; on ties the lower index wins.
module min_vt_tree #(
  parameter int N = 2,
  parameter int W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N-1:0][W-1:0] in_vals,
  output logic                out_valid,
  output logic [W-1:0]        out_val
);
  localparam int L = $clog2(N);
  localparam int P = 1 << L;

  logic [L-1:0] vld_reg;

  for (genvar gi = 0; gi <= L; gi++) begin : lvl
    logic [W-1:0] v [(P >> gi)];
    if (gi == 0) begin : g_leaf
      for (genvar gj = 0; gj < P; gj++) begin : g_in
        if (gj < N) begin : g_real
          assign v[gj] = in_vals[gj];
        end else begin : g_pad
          assign v[gj] = {W{1'b1}};
        end
      end
    end else begin : g_node
      for (genvar gj = 0; gj < (P >> gi); gj++) begin : g_cmp
        // Strict less-than keeps the even (lower-index) operand on ties.
        always_ff @(posedge clk) begin
          v[gj] <= (lvl[gi-1].v[2*gj+1] < lvl[gi-1].v[2*gj]) ?
                   lvl[gi-1].v[2*gj+1] : lvl[gi-1].v[2*gj];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= L'({vld_reg, in_valid});
    end
  end

  assign out_valid = vld_reg[L-1];
  assign out_val   = lvl[L].v[0];

endmodule

// File: rtl/gvt_reducer.sv
// Periodic GVT reduction: request LVTs, collect one per tile, take the minimum
// through a pipelined tree and publish it as the new GVT if it does not regress.
module gvt_reducer
  import gvt_reducer_pkg::*;
#(
  parameter int N_TILES        = 1,
  parameter int TS_WIDTH       = 32,
  parameter int TB_WIDTH       = 32,
  parameter int LOG_GVT_PERIOD = 5
) (
  input  logic          clk,
  input  logic          rst,
  gvt_reducer_if.master bus
);
  localparam int GVT_PERIOD = 2 ** LOG_GVT_PERIOD;
  localparam int VT_WIDTH   = TS_WIDTH + TB_WIDTH;
  localparam int L          = $clog2(N_TILES);
  // Decisions are taken one cycle early so lvt_req is registered yet still
  // coincides with pcnt == all-ones.
  localparam logic [LOG_GVT_PERIOD-1:0] PCNT_PRE = LOG_GVT_PERIOD'(GVT_PERIOD - 2);

  state_t                            state_reg, state_next;
  logic [LOG_GVT_PERIOD-1:0]         pcnt_reg;
  logic [N_TILES-1:0]                got_reg, got_next, take;
  logic [N_TILES-1:0][VT_WIDTH-1:0]  cap_reg, cap_next;
  logic                              lvt_req_reg, lvt_req_next;
  logic                              gvt_valid_reg, gvt_valid_next;
  logic                              regress_reg, regress_next;
  logic [VT_WIDTH-1:0]               gvt_reg, gvt_next;
  logic [15:0]                       missed_reg, missed_next;

  logic                boundary, req_fire, accept, round_full;
  logic                tree_valid, reduce_done;
  logic [VT_WIDTH-1:0] tree_min;

  assign boundary   = (pcnt_reg == PCNT_PRE);
  assign req_fire   = (state_reg == ST_IDLE) && boundary && bus.enable;
  // The request cycle itself is still COLLECT but must not accept responses.
  assign accept     = (state_reg == ST_COLLECT) && !lvt_req_reg;
  assign take       = accept ? (bus.lvt_valid & ~got_reg) : '0;
  assign got_next   = req_fire ? '0 : (got_reg | take);
  assign round_full = accept && (&(got_reg | take));

  for (genvar gi = 0; gi < N_TILES; gi++) begin : g_cap
    assign cap_next[gi] = req_fire ? '0 : (take[gi] ? bus.lvt[gi] : cap_reg[gi]);
  end

  // The tree sees cap_next so the final response enters stage 1 directly.
  if (L == 0) begin : g_direct
    assign tree_min   = cap_next[0];
    assign tree_valid = round_full;
  end else begin : g_tree
    min_vt_tree #(
      .N (N_TILES),
      .W (VT_WIDTH)
    ) u_tree (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (round_full),
      .in_vals   (cap_next),
      .out_valid (tree_valid),
      .out_val   (tree_min)
    );
  end

  assign reduce_done = (L == 0) ? 1'b1 : tree_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (req_fire)    state_next = ST_COLLECT;
      ST_COLLECT: if (round_full)  state_next = ST_REDUCE;
      ST_REDUCE:  if (reduce_done) state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    lvt_req_next   = req_fire;
    gvt_valid_next = 1'b0;
    gvt_next       = gvt_reg;
    regress_next   = regress_reg;
    missed_next    = missed_reg;
    if (tree_valid) begin
      if (tree_min >= gvt_reg) begin
        gvt_next       = tree_min;
        gvt_valid_next = 1'b1;
      end else begin
        regress_next   = 1'b1;
      end
    end
    if (boundary && (state_reg != ST_IDLE)) begin
      missed_next = sat_inc16(missed_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_reg      <= '0;
      got_reg       <= '0;
      cap_reg       <= '0;
      lvt_req_reg   <= 1'b0;
      gvt_valid_reg <= 1'b0;
      regress_reg   <= 1'b0;
      gvt_reg       <= '0;
      missed_reg    <= '0;
    end else begin
      pcnt_reg      <= pcnt_reg + 1'b1;
      got_reg       <= got_next;
      cap_reg       <= cap_next;
      lvt_req_reg   <= lvt_req_next;
      gvt_valid_reg <= gvt_valid_next;
      regress_reg   <= regress_next;
      gvt_reg       <= gvt_next;
      missed_reg    <= missed_next;
    end
  end

  assign bus.lvt_req        = lvt_req_reg;
  assign bus.gvt            = gvt_reg;
  assign bus.gvt_valid      = gvt_valid_reg;
  assign bus.gvt_regress    = regress_reg;
  assign bus.missed_periods = missed_reg;

endmodule

// File: tb/tb_gvt_reducer.sv
// Directed bench for gvt_reducer: a 4-tile instance for the reduction scenarios
// and a 1-tile instance for the monotonic (regression) check.
module tb_gvt_reducer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4;
  logic rst1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc4     = 0;

  gvt_reducer_if #(.N_TILES(4), .TS_WIDTH(32), .TB_WIDTH(32)) bus4 ();
  gvt_reducer_if #(.N_TILES(1), .TS_WIDTH(32), .TB_WIDTH(32)) bus1 ();

  gvt_reducer #(.N_TILES(4), .TS_WIDTH(32), .TB_WIDTH(32), .LOG_GVT_PERIOD(5)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  gvt_reducer #(.N_TILES(1), .TS_WIDTH(32), .TB_WIDTH(32), .LOG_GVT_PERIOD(5)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  // Cycle index since the last release of rst4 (cycle 0 = first cycle after release).
  always @(posedge clk) begin
    if (rst4) cyc4 <= 0;
    else      cyc4 <= cyc4 + 1;
  end

  function automatic logic [63:0] vt(input int unsigned ts, input int unsigned tb);
    return {ts, tb};
  endfunction

  task automatic reset4();
    rst4 = 1'b1;
    bus4.enable = 1'b1;
    bus4.lvt_valid = '0;
    bus4.lvt = '0;
    repeat (3) @(negedge clk);
    rst4 = 1'b0;
  endtask

  task automatic reset1();
    rst1 = 1'b1;
    bus1.enable = 1'b1;
    bus1.lvt_valid = '0;
    bus1.lvt = '0;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
  endtask

  task automatic wait_req4();
    int n = 0;
    while (bus4.lvt_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus4.lvt_req !== 1'b1) begin
      failures++;
      $display("FAIL wait_req4 got=%b exp=1 (timeout)", bus4.lvt_req);
    end
  endtask

  task automatic wait_req1();
    int n = 0;
    while (bus1.lvt_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus1.lvt_req !== 1'b1) begin
      failures++;
      $display("FAIL wait_req1 got=%b exp=1 (timeout)", bus1.lvt_req);
    end
  endtask

  task automatic send4(input int idx, input logic [63:0] v);
    bus4.lvt_valid[idx] = 1'b1;
    bus4.lvt[idx] = v;
    @(negedge clk);
    bus4.lvt_valid = '0;
  endtask

  task automatic send1(input logic [63:0] v);
    bus1.lvt_valid = 1'b1;
    bus1.lvt[0] = v;
    @(negedge clk);
    bus1.lvt_valid = '0;
  endtask

  // Counts cycles from the cycle after the last response until gvt_valid (or gives up).
  task automatic wait_pulse4(output int lat);
    lat = 1;
    while (bus4.gvt_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b1;
    rst1 = 1'b1;
    bus4.enable = 1'b1;
    bus4.lvt_valid = '0;
    bus4.lvt = '0;
    bus1.enable = 1'b1;
    bus1.lvt_valid = '0;
    bus1.lvt = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus4.gvt !== 64'd0 || bus4.gvt_valid !== 1'b0 || bus4.lvt_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b/%b exp=0/0/0", bus4.gvt, bus4.gvt_valid, bus4.lvt_req);
    end
    checks++;
    if (bus4.gvt_regress !== 1'b0 || bus4.missed_periods !== 16'd0) begin
      failures++;
      $display("FAIL reset_flags got=%b/%0d exp=0/0", bus4.gvt_regress, bus4.missed_periods);
    end
    rst4 = 1'b0;
    rst1 = 1'b0;
    wait_req4();
    checks++;
    if (cyc4 !== 31) begin
      failures++;
      $display("FAIL first_req_cycle got=%0d exp=31", cyc4);
    end
    $display("test_reset: first request at cycle %0d", cyc4);
  endtask

  task automatic test_min_reduce();
    int lat;
    reset4();
    wait_req4();
    @(negedge clk);
    send4(3, vt(90, 0));
    send4(0, vt(50, 1));
    send4(2, vt(20, 3));
    send4(1, vt(20, 7));
    wait_pulse4(lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL min4_latency got=%0d exp=3", lat);
    end
    checks++;
    if (bus4.gvt !== vt(20, 3)) begin
      failures++;
      $display("FAIL min4_gvt got=%h exp=%h", bus4.gvt, vt(20, 3));
    end
    $display("round min4: gvt=%h latency=%0d", bus4.gvt, lat);
    @(negedge clk);
    checks++;
    if (bus4.gvt_valid !== 1'b0) begin
      failures++;
      $display("FAIL min4_single_pulse got=%b exp=0", bus4.gvt_valid);
    end
    // Second round: minimum equals current gvt (not a regression), with a tie.
    wait_req4();
    @(negedge clk);
    send4(0, vt(30, 0));
    send4(1, vt(20, 3));
    send4(2, vt(40, 9));
    send4(3, vt(20, 3));
    wait_pulse4(lat);
    checks++;
    if (bus4.gvt_valid !== 1'b1 || bus4.gvt !== vt(20, 3)) begin
      failures++;
      $display("FAIL equal_gvt got=%b/%h exp=1/%h", bus4.gvt_valid, bus4.gvt, vt(20, 3));
    end
    checks++;
    if (bus4.gvt_regress !== 1'b0) begin
      failures++;
      $display("FAIL equal_no_regress got=%b exp=0", bus4.gvt_regress);
    end
    $display("round equal: gvt=%h", bus4.gvt);
  endtask

  task automatic test_regress();
    int seen;
    reset1();
    wait_req1();
    @(negedge clk);
    send1(vt(10, 0));
    checks++;
    if (bus1.gvt_valid !== 1'b1 || bus1.gvt !== vt(10, 0)) begin
      failures++;
      $display("FAIL n1_first got=%b/%h exp=1/%h", bus1.gvt_valid, bus1.gvt, vt(10, 0));
    end
    $display("round n1 first: gvt=%h", bus1.gvt);
    wait_req1();
    @(negedge clk);
    send1(vt(5, 0));
    seen = 0;
    repeat (4) begin
      if (bus1.gvt_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL n1_regress_pulse got=%0d exp=0", seen);
    end
    checks++;
    if (bus1.gvt_regress !== 1'b1 || bus1.gvt !== vt(10, 0)) begin
      failures++;
      $display("FAIL n1_regress got=%b/%h exp=1/%h", bus1.gvt_regress, bus1.gvt, vt(10, 0));
    end
    $display("round n1 regress: gvt=%h regress=%b", bus1.gvt, bus1.gvt_regress);
    wait_req1();
    @(negedge clk);
    send1(vt(20, 0));
    checks++;
    if (bus1.gvt_valid !== 1'b1 || bus1.gvt !== vt(20, 0) || bus1.gvt_regress !== 1'b1) begin
      failures++;
      $display("FAIL n1_sticky got=%b/%h/%b exp=1/%h/1", bus1.gvt_valid, bus1.gvt,
               bus1.gvt_regress, vt(20, 0));
    end
    $display("round n1 after regress: gvt=%h", bus1.gvt);
  endtask

  task automatic test_withhold();
    int pulses;
    int reqs;
    int n;
    reset4();
    wait_req4();
    @(negedge clk);
    send4(0, vt(100, 0));
    send4(1, vt(200, 0));
    send4(3, vt(300, 0));
    pulses = 0;
    reqs = 0;
    repeat (96) begin
      if (bus4.gvt_valid === 1'b1) pulses++;
      if (bus4.lvt_req === 1'b1) reqs++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0 || reqs !== 0) begin
      failures++;
      $display("FAIL withhold_quiet got=%0d/%0d exp=0/0", pulses, reqs);
    end
    checks++;
    if (bus4.missed_periods !== 16'd3) begin
      failures++;
      $display("FAIL withhold_missed got=%0d exp=3", bus4.missed_periods);
    end
    send4(2, vt(150, 0));
    pulses = 0;
    n = 0;
    while (bus4.lvt_req !== 1'b1 && n < 100) begin
      if (bus4.gvt_valid === 1'b1) pulses++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL withhold_one_pulse got=%0d exp=1", pulses);
    end
    checks++;
    if (bus4.lvt_req !== 1'b1 || cyc4 !== 159) begin
      failures++;
      $display("FAIL withhold_next_req got=%b@%0d exp=1@159", bus4.lvt_req, cyc4);
    end
    checks++;
    if (bus4.gvt !== vt(100, 0) || bus4.missed_periods !== 16'd3) begin
      failures++;
      $display("FAIL withhold_gvt got=%h/%0d exp=%h/3", bus4.gvt, bus4.missed_periods, vt(100, 0));
    end
    $display("round withhold: gvt=%h missed=%0d", bus4.gvt, bus4.missed_periods);
  endtask

  task automatic test_duplicate();
    int lat;
    reset4();
    wait_req4();
    send4(0, vt(2, 0));
    send4(0, vt(5, 0));
    send4(0, vt(1, 0));
    send4(1, vt(7, 0));
    send4(2, vt(9, 0));
    send4(3, vt(6, 0));
    wait_pulse4(lat);
    checks++;
    if (bus4.gvt_valid !== 1'b1 || bus4.gvt !== vt(5, 0)) begin
      failures++;
      $display("FAIL duplicate_gvt got=%b/%h exp=1/%h", bus4.gvt_valid, bus4.gvt, vt(5, 0));
    end
    $display("round duplicate: gvt=%h", bus4.gvt);
  endtask

  task automatic test_enable();
    int lat;
    int reqs;
    reset4();
    wait_req4();
    @(negedge clk);
    bus4.enable = 1'b0;
    send4(1, vt(41, 0));
    send4(0, vt(40, 0));
    send4(3, vt(43, 0));
    send4(2, vt(42, 0));
    wait_pulse4(lat);
    checks++;
    if (bus4.gvt_valid !== 1'b1 || bus4.gvt !== vt(40, 0)) begin
      failures++;
      $display("FAIL enable_round got=%b/%h exp=1/%h", bus4.gvt_valid, bus4.gvt, vt(40, 0));
    end
    reqs = 0;
    while (cyc4 < 100) begin
      if (bus4.lvt_req === 1'b1) reqs++;
      @(negedge clk);
    end
    checks++;
    if (reqs !== 0) begin
      failures++;
      $display("FAIL enable_low_reqs got=%0d exp=0", reqs);
    end
    bus4.enable = 1'b1;
    wait_req4();
    checks++;
    if (cyc4 !== 127 || bus4.missed_periods !== 16'd0) begin
      failures++;
      $display("FAIL enable_resume got=%0d/%0d exp=127/0", cyc4, bus4.missed_periods);
    end
    $display("round enable: gvt=%h resumed at cycle %0d", bus4.gvt, cyc4);
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    int n;
    reset4();
    wait_req4();
    @(negedge clk);
    send4(0, vt(60, 0));
    send4(1, vt(61, 0));
    send4(2, vt(62, 0));
    send4(3, vt(63, 0));
    wait_pulse4(lat);
    checks++;
    if (bus4.gvt !== vt(60, 0)) begin
      failures++;
      $display("FAIL pre_reset_gvt got=%h exp=%h", bus4.gvt, vt(60, 0));
    end
    wait_req4();
    @(negedge clk);
    send4(0, vt(1, 0));
    send4(1, vt(2, 0));
    send4(2, vt(3, 0));
    rst4 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus4.gvt !== 64'd0 || bus4.gvt_valid !== 1'b0 || bus4.lvt_req !== 1'b0 ||
        bus4.gvt_regress !== 1'b0 || bus4.missed_periods !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset got=%h/%b/%b/%b/%0d exp=0/0/0/0/0", bus4.gvt, bus4.gvt_valid,
               bus4.lvt_req, bus4.gvt_regress, bus4.missed_periods);
    end
    rst4 = 1'b0;
    pulses = 0;
    n = 0;
    while (bus4.lvt_req !== 1'b1 && n < 100) begin
      if (bus4.gvt_valid === 1'b1) pulses++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (pulses !== 0 || cyc4 !== 31) begin
      failures++;
      $display("FAIL post_reset_req got=%0d@%0d exp=0@31", pulses, cyc4);
    end
    @(negedge clk);
    send4(0, vt(70, 0));
    send4(1, vt(80, 0));
    send4(2, vt(90, 0));
    send4(3, vt(75, 0));
    wait_pulse4(lat);
    checks++;
    if (bus4.gvt_valid !== 1'b1 || bus4.gvt !== vt(70, 0) || lat !== 3) begin
      failures++;
      $display("FAIL post_reset_round got=%b/%h/%0d exp=1/%h/3", bus4.gvt_valid, bus4.gvt, lat,
               vt(70, 0));
    end
    $display("round after reset: gvt=%h", bus4.gvt);
  endtask

  initial begin
    test_reset();
    test_min_reduce();
    test_regress();
    test_withhold();
    test_duplicate();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
